bullet_pool: RTL and testbench

BULLET_POOL -- requirements
Module: bullet_pool

---
 rtl/bullet_pkg.sv | 27 ++
 rtl/bullet_alloc.sv | 31 +++
 rtl/bullet_pool.sv | 232 +++++++++++++++++++++++
 tb/tb_bullet_pool.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared types for the bullet pool: slot record, colour codes and sweep FSM states.
package bullet_pkg;

    // Slot geometry is stored at this fixed width; the pool zero-extends narrower COORD_W values.
    localparam int BULLET_MAX_W = 16;

    localparam logic [2:0] COLOR_WHITE = 3'b000;
    localparam logic [2:0] COLOR_GREEN = 3'b001;
    localparam logic [2:0] COLOR_BLUE  = 3'b010;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } pool_state_e;

    typedef struct packed {
        logic                    active;
        logic [2:0]              color;
        logic signed [3:0]       vx;
        logic signed [3:0]       vy;
        logic [BULLET_MAX_W-1:0] x;
        logic [BULLET_MAX_W-1:0] y;
        logic [BULLET_MAX_W-1:0] w;
        logic [BULLET_MAX_W-1:0] h;
    } bullet_t;

endpackage

// File: rtl/bullet_alloc.sv
// Lowest-free-slot priority encoder used to place newly spawned bullets.
module bullet_alloc #(
    parameter int NUM_BULLETS = 8
) (
    input  logic [NUM_BULLETS-1:0]         active,
    output logic [$clog2(NUM_BULLETS)-1:0] free_idx,
    output logic                           any_free
);

    localparam int IW = $clog2(NUM_BULLETS);

    logic [NUM_BULLETS-1:0] free_vec;

    genvar gi;
    for (gi = 0; gi < NUM_BULLETS; gi++) begin : g_free
        assign free_vec[gi] = ~active[gi];
    end

    // Scan from the top so the lowest free slot is the last assignment to win.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    assign any_free = |free_vec;

endmodule

// File: rtl/bullet_pool.sv
// Pool of moving bullets: spawn into the lowest free slot, sweep one slot per cycle per frame.
// Build macro BULLET_POOL_COLLIDE_EN adds the player box inputs and the one-cycle hit output.
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 8,
    parameter int COORD_W     = 8,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            spawn_valid,
    output logic                            spawn_ready,
    input  logic [COORD_W-1:0]              spawn_x,
    input  logic [COORD_W-1:0]              spawn_y,
    input  logic [COORD_W-1:0]              spawn_w,
    input  logic [COORD_W-1:0]              spawn_h,
    input  logic [3:0]                      spawn_vx,
    input  logic [3:0]                      spawn_vy,
    input  logic [2:0]                      spawn_color,
    input  logic                            frame_tick,
    output logic                            busy,
    input  logic [$clog2(NUM_BULLETS)-1:0]  index1,
    input  logic [$clog2(NUM_BULLETS)-1:0]  index2,
    output logic [2*COORD_W-1:0]            position1,
    output logic [2*COORD_W-1:0]            position2,
    output logic [2*COORD_W-1:0]            size1,
    output logic [2*COORD_W-1:0]            size2,
    output logic [2:0]                      color1,
    output logic [2:0]                      color2,
    output logic                            isRender1,
    output logic                            isRender2,
    output logic [$clog2(NUM_BULLETS):0]    active_count
`ifdef BULLET_POOL_COLLIDE_EN
    ,
    input  logic [COORD_W-1:0]              player_x,
    input  logic [COORD_W-1:0]              player_y,
    input  logic [COORD_W-1:0]              player_w,
    input  logic [COORD_W-1:0]              player_h,
    output logic                            hit
`endif
);

    localparam int IW    = $clog2(NUM_BULLETS);
    localparam int CNT_W = IW + 1;
    // Wide enough that x+v+w never wraps, so bounds tests are exact signed compares.
    localparam int SW    = BULLET_MAX_W + 3;
    localparam logic signed [SW-1:0] SCR_W_S  = SW'(SCREEN_W);
    localparam logic signed [SW-1:0] SCR_H_S  = SW'(SCREEN_H);
    localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_BULLETS - 1);

    bullet_t             slot_reg [NUM_BULLETS];
    pool_state_e         state_reg;
    logic [IW-1:0]       sweep_idx_reg;
    logic                pending_reg;
    logic [CNT_W-1:0]    count_reg;

    logic [NUM_BULLETS-1:0] active_vec;
    logic [IW-1:0]          free_idx;
    logic                   any_free;
    logic                   spawn_fire;
    bullet_t                spawn_rec;

    genvar gi;
    for (gi = 0; gi < NUM_BULLETS; gi++) begin : g_active
        assign active_vec[gi] = slot_reg[gi].active;
    end

    bullet_alloc #(
        .NUM_BULLETS (NUM_BULLETS)
    ) u_alloc (
        .active   (active_vec),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    assign spawn_ready = !reset && (state_reg == IDLE) && any_free;
    assign spawn_fire  = spawn_valid && spawn_ready;

    always_comb begin
        spawn_rec        = '0;
        spawn_rec.active = 1'b1;
        spawn_rec.color  = spawn_color;
        spawn_rec.vx     = $signed(spawn_vx);
        spawn_rec.vy     = $signed(spawn_vy);
        spawn_rec.x      = BULLET_MAX_W'(spawn_x);
        spawn_rec.y      = BULLET_MAX_W'(spawn_y);
        spawn_rec.w      = BULLET_MAX_W'(spawn_w);
        spawn_rec.h      = BULLET_MAX_W'(spawn_h);
    end

    // Motion datapath for the slot currently addressed by the sweep.
    logic signed [SW-1:0] cur_x, cur_y, cur_w, cur_h, cur_vx, cur_vy;
    logic signed [SW-1:0] nx, ny, nx_end, ny_end;
    logic                 cur_active;
    logic                 out_of_bounds;
    logic                 collide;
    logic                 despawn;

    assign cur_active = slot_reg[sweep_idx_reg].active;
    assign cur_x      = SW'(slot_reg[sweep_idx_reg].x);
    assign cur_y      = SW'(slot_reg[sweep_idx_reg].y);
    assign cur_w      = SW'(slot_reg[sweep_idx_reg].w);
    assign cur_h      = SW'(slot_reg[sweep_idx_reg].h);
    assign cur_vx     = {{(SW-4){slot_reg[sweep_idx_reg].vx[3]}}, slot_reg[sweep_idx_reg].vx};
    assign cur_vy     = {{(SW-4){slot_reg[sweep_idx_reg].vy[3]}}, slot_reg[sweep_idx_reg].vy};

    assign nx     = cur_x + cur_vx;
    assign ny     = cur_y + cur_vy;
    assign nx_end = nx + cur_w;
    assign ny_end = ny + cur_h;

    assign out_of_bounds = nx[SW-1] || ny[SW-1] || (nx_end > SCR_W_S) || (ny_end > SCR_H_S);

`ifdef BULLET_POOL_COLLIDE_EN
    logic signed [SW-1:0] px, py, pw, ph;
    logic                 hit_reg;

    assign px = SW'(player_x);
    assign py = SW'(player_y);
    assign pw = SW'(player_w);
    assign ph = SW'(player_h);

    // Strict overlap: boxes that merely touch along an edge do not collide.
    assign collide = (nx < px + pw) && (nx_end > px) && (ny < py + ph) && (ny_end > py);

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_reg <= 1'b0;
        end else begin
            hit_reg <= (state_reg == SWEEP) && cur_active && !out_of_bounds && collide;
        end
    end

    assign hit = hit_reg && !reset;
`else
    assign collide = 1'b0;
`endif

    assign despawn = (state_reg == SWEEP) && cur_active && (out_of_bounds || collide);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            sweep_idx_reg <= '0;
            pending_reg   <= 1'b0;
            count_reg     <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (spawn_fire) begin
                        slot_reg[free_idx] <= spawn_rec;
                    end
                    // A frame queued during the previous sweep starts here.
                    if (frame_tick || pending_reg) begin
                        state_reg     <= SWEEP;
                        sweep_idx_reg <= '0;
                        pending_reg   <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (frame_tick) begin
                        pending_reg <= 1'b1;
                    end
                    if (cur_active) begin
                        if (out_of_bounds) begin
                            slot_reg[sweep_idx_reg].active <= 1'b0;
                        end else begin
                            slot_reg[sweep_idx_reg].x <= nx[BULLET_MAX_W-1:0];
                            slot_reg[sweep_idx_reg].y <= ny[BULLET_MAX_W-1:0];
                            if (collide) begin
                                slot_reg[sweep_idx_reg].active <= 1'b0;
                            end
                        end
                    end
                    if (sweep_idx_reg == LAST_IDX) begin
                        state_reg     <= IDLE;
                        sweep_idx_reg <= '0;
                    end else begin
                        sweep_idx_reg <= sweep_idx_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
            count_reg <= count_reg + CNT_W'(spawn_fire) - CNT_W'(despawn);
        end
    end

    assign busy         = (state_reg == SWEEP) && !reset;
    assign active_count = reset ? '0 : count_reg;

    // Two identical combinational read ports.
    logic [IW-1:0]          rd_idx    [2];
    logic [2*COORD_W-1:0]   rd_pos    [2];
    logic [2*COORD_W-1:0]   rd_size   [2];
    logic [2:0]             rd_color  [2];
    logic                   rd_render [2];

    assign rd_idx[0] = index1;
    assign rd_idx[1] = index2;

    for (gi = 0; gi < 2; gi++) begin : g_read
        logic rd_ok;
        if ((1 << IW) > NUM_BULLETS) begin : g_range
            assign rd_ok = !reset && (CNT_W'(rd_idx[gi]) < CNT_W'(NUM_BULLETS));
        end else begin : g_full
            assign rd_ok = !reset;
        end
        assign rd_pos[gi]    = rd_ok ? {slot_reg[rd_idx[gi]].x[COORD_W-1:0],
                                        slot_reg[rd_idx[gi]].y[COORD_W-1:0]} : '0;
        assign rd_size[gi]   = rd_ok ? {slot_reg[rd_idx[gi]].w[COORD_W-1:0],
                                        slot_reg[rd_idx[gi]].h[COORD_W-1:0]} : '0;
        assign rd_color[gi]  = rd_ok ? slot_reg[rd_idx[gi]].color : '0;
        assign rd_render[gi] = rd_ok && slot_reg[rd_idx[gi]].active;
    end

    assign position1 = rd_pos[0];
    assign position2 = rd_pos[1];
    assign size1     = rd_size[0];
    assign size2     = rd_size[1];
    assign color1    = rd_color[0];
    assign color2    = rd_color[1];
    assign isRender1 = rd_render[0];
    assign isRender2 = rd_render[1];

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: boundary table, hand-written multi-cycle sequences, random ops vs model.
`timescale 1ns/1ps
module tb_bullet_pool;

    localparam int N     = 8;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spawn_valid = 1'b0;
    logic       spawn_ready;
    logic [7:0] spawn_x = '0, spawn_y = '0, spawn_w = '0, spawn_h = '0;
    logic [3:0] spawn_vx = '0, spawn_vy = '0;
    logic [2:0] spawn_color = '0;
    logic       frame_tick = 1'b0;
    logic       busy;
    logic [2:0] index1 = '0, index2 = '0;
    logic [15:0] position1, position2, size1, size2;
    logic [2:0] color1, color2;
    logic       isRender1, isRender2;
    logic [3:0] active_count;
`ifdef BULLET_POOL_COLLIDE_EN
    logic [7:0] player_x = '0, player_y = '0, player_w = '0, player_h = '0;
    logic       hit;
`endif

    always #10 clk = ~clk;

    bullet_pool #(
        .NUM_BULLETS (N),
        .COORD_W     (8),
        .SCREEN_W    (SCR_W),
        .SCREEN_H    (SCR_H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spawn_valid  (spawn_valid),
        .spawn_ready  (spawn_ready),
        .spawn_x      (spawn_x),
        .spawn_y      (spawn_y),
        .spawn_w      (spawn_w),
        .spawn_h      (spawn_h),
        .spawn_vx     (spawn_vx),
        .spawn_vy     (spawn_vy),
        .spawn_color  (spawn_color),
        .frame_tick   (frame_tick),
        .busy         (busy),
        .index1       (index1),
        .index2       (index2),
        .position1    (position1),
        .position2    (position2),
        .size1        (size1),
        .size2        (size2),
        .color1       (color1),
        .color2       (color2),
        .isRender1    (isRender1),
        .isRender2    (isRender2),
        .active_count (active_count)
`ifdef BULLET_POOL_COLLIDE_EN
        ,
        .player_x     (player_x),
        .player_y     (player_y),
        .player_w     (player_w),
        .player_h     (player_h),
        .hit          (hit)
`endif
    );

    // Behavioural model: plain integer slot contents.
    int m_act [N], m_x [N], m_y [N], m_w [N], m_h [N], m_vx [N], m_vy [N], m_col [N];
    bit m_known [N];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int x, y, w, h, vx, vy, col;
        int exp_act, exp_x, exp_y;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int m_free();
        for (int i = 0; i < N; i++) if (m_act[i] == 0) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_act[i];
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0;
            m_known[i] = 1'b0;
        end
    endtask

    task automatic m_sweep(output int hits);
        int nx, ny;
        hits = 0;
        for (int i = 0; i < N; i++) begin
            if (m_act[i] != 0) begin
                nx = m_x[i] + m_vx[i];
                ny = m_y[i] + m_vy[i];
                if (nx < 0 || ny < 0 || nx + m_w[i] > SCR_W || ny + m_h[i] > SCR_H) begin
                    m_act[i] = 0;
                end else begin
                    m_x[i] = nx;
                    m_y[i] = ny;
`ifdef BULLET_POOL_COLLIDE_EN
                    if (nx < int'(player_x) + int'(player_w) && nx + m_w[i] > int'(player_x) &&
                        ny < int'(player_y) + int'(player_h) && ny + m_h[i] > int'(player_y)) begin
                        m_act[i] = 0;
                        hits++;
                    end
`endif
                end
            end
        end
    endtask

    // Counts busy cycles over a fixed window, optionally pulsing frame_tick at cycles c1/c2.
    task automatic wait_sweep(input int sweeps, input int c1, input int c2);
        int n = 0, hits = 0, exp_hits = 0, h;
        for (int s = 0; s < sweeps; s++) begin
            m_sweep(h);
            exp_hits += h;
        end
        for (int c = 0; c < 40; c++) begin
            if (busy) n++;
`ifdef BULLET_POOL_COLLIDE_EN
            if (hit) hits++;
`endif
            frame_tick = (c == c1 || c == c2);
            @(negedge clk);
        end
        frame_tick = 1'b0;
        chk("busy_cycles", n, 8 * sweeps);
`ifdef BULLET_POOL_COLLIDE_EN
        chk("hit_pulses", hits, exp_hits);
`endif
    endtask

    task automatic do_tick(input int sweeps, input int c1, input int c2);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        $display("tick  sweeps=%0d live_before=%0d", sweeps, m_count());
        wait_sweep(sweeps, c1, c2);
    endtask

    task automatic do_spawn(input int x, y, w, h, vx, vy, col, input bit with_tick);
        int slot = m_free();
        chk("spawn_ready", spawn_ready, slot >= 0);
        spawn_x = 8'(x); spawn_y = 8'(y); spawn_w = 8'(w); spawn_h = 8'(h);
        spawn_vx = 4'(vx); spawn_vy = 4'(vy); spawn_color = 3'(col);
        spawn_valid = 1'b1;
        frame_tick = with_tick;
        @(negedge clk);
        spawn_valid = 1'b0;
        frame_tick = 1'b0;
        if (slot >= 0) begin
            m_act[slot] = 1; m_known[slot] = 1'b1;
            m_x[slot] = x; m_y[slot] = y; m_w[slot] = w; m_h[slot] = h;
            m_vx[slot] = vx; m_vy[slot] = vy; m_col[slot] = col;
        end
        $display("spawn slot=%0d x=%0d y=%0d w=%0d h=%0d vx=%0d vy=%0d color=%0d tick=%0d",
                 slot, x, y, w, h, vx, vy, col, with_tick);
        if (with_tick) wait_sweep(1, -1, -1);
    endtask

    task automatic chk_slot(input int i, input logic [15:0] pos, input logic [15:0] sz,
                            input logic [2:0] col, input logic ren);
        logic [15:0] e_pos, e_sz;
        chk($sformatf("isRender[%0d]", i), ren, m_act[i]);
        if (m_known[i]) begin
            e_pos = {8'(m_x[i]), 8'(m_y[i])};
            e_sz  = {8'(m_w[i]), 8'(m_h[i])};
            chk($sformatf("position[%0d]", i), pos, e_pos);
            chk($sformatf("size[%0d]", i), sz, e_sz);
            chk($sformatf("color[%0d]", i), col, m_col[i]);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i += 2) begin
            index1 = 3'(i);
            index2 = 3'(i + 1);
            #1;
            chk_slot(i, position1, size1, color1, isRender1);
            chk_slot(i + 1, position2, size2, color2, isRender2);
        end
        chk("active_count", active_count, m_count());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        spawn_valid = 1'b0;
        frame_tick = 1'b0;
        index1 = '0;
        #1;
        chk("rst_ready", spawn_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", active_count, 0);
        chk("rst_render", isRender1, 0);
        chk("rst_pos", position1, 0);
        @(negedge clk);
        chk("rst_busy_after_edge", busy, 0);
        reset = 1'b0;
        m_reset();
        #1;
        chk("post_rst_ready", spawn_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_count", active_count, 0);
        chk("post_rst_render", isRender1, 0);
        chk("post_rst_pos", position1, 0);
        chk("post_rst_size", size1, 0);
        chk("post_rst_color", color1, 0);
        $display("reset done");
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{x:10,  y:20,  w:4,  h:4, vx:2,  vy:-1, col:1, exp_act:1, exp_x:12,  exp_y:19};
        tbl[1] = '{x:157, y:10,  w:4,  h:4, vx:1,  vy:0,  col:0, exp_act:0, exp_x:157, exp_y:10};
        tbl[2] = '{x:155, y:10,  w:4,  h:4, vx:1,  vy:0,  col:2, exp_act:1, exp_x:156, exp_y:10};
        tbl[3] = '{x:50,  y:0,   w:4,  h:4, vx:0,  vy:-1, col:5, exp_act:0, exp_x:50,  exp_y:0};
        tbl[4] = '{x:0,   y:5,   w:2,  h:2, vx:-1, vy:0,  col:7, exp_act:0, exp_x:0,   exp_y:5};
        tbl[5] = '{x:100, y:115, w:4,  h:5, vx:0,  vy:0,  col:3, exp_act:1, exp_x:100, exp_y:115};
        tbl[6] = '{x:100, y:116, w:4,  h:4, vx:-8, vy:1,  col:1, exp_act:0, exp_x:100, exp_y:116};
        tbl[7] = '{x:3,   y:3,   w:1,  h:1, vx:-3, vy:-3, col:4, exp_act:1, exp_x:0,   exp_y:0};
        tbl[8] = '{x:150, y:60,  w:10, h:10, vx:7, vy:0,  col:6, exp_act:0, exp_x:150, exp_y:60};

        @(negedge clk);
        for (int t = 0; t < 9; t++) begin
            do_reset();
            do_spawn(tbl[t].x, tbl[t].y, tbl[t].w, tbl[t].h, tbl[t].vx, tbl[t].vy, tbl[t].col, 1'b0);
            index1 = '0;
            #1;
            chk($sformatf("tbl%0d_spawn_pos", t), position1, {8'(tbl[t].x), 8'(tbl[t].y)});
            chk($sformatf("tbl%0d_spawn_count", t), active_count, 1);
            do_tick(1, -1, -1);
            index1 = '0;
            #1;
            chk($sformatf("tbl%0d_render", t), isRender1, tbl[t].exp_act);
            chk($sformatf("tbl%0d_pos", t), position1, {8'(tbl[t].exp_x), 8'(tbl[t].exp_y)});
            chk($sformatf("tbl%0d_color", t), color1, tbl[t].col);
            chk($sformatf("tbl%0d_count", t), active_count, tbl[t].exp_act);
            check_all();
        end

        // Full pool, then slot 3 leaves the screen and is reused by the next spawn.
        do_reset();
        for (int i = 0; i < N; i++) begin
            do_spawn((i == 3) ? 157 : 10 + 15 * i, 30, 4, 4, (i == 3) ? 1 : 0, 0, i, 1'b0);
        end
        #1;
        chk("full_ready", spawn_ready, 0);
        chk("full_count", active_count, 8);
        do_tick(1, -1, -1);
        check_all();
        do_spawn(60, 60, 4, 4, 0, 0, 2, 1'b0);
        index1 = 3'd3;
        #1;
        chk("reuse_slot3_pos", position1, 16'h3C3C);
        chk("reuse_slot3_render", isRender1, 1);
        check_all();

        // Two ticks during a sweep queue exactly one extra sweep.
        do_reset();
        do_spawn(20, 20, 4, 4, 3, 2, 1, 1'b0);
        do_spawn(140, 100, 8, 8, 2, 1, 2, 1'b0);
        do_tick(2, 1, 4);
        check_all();

        // Reset at sweep cycle 3 aborts the sweep and drops a queued frame.
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        reset = 1'b1;
        index1 = '0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_count", active_count, 0);
        chk("midrst_ready", spawn_ready, 0);
        chk("midrst_render", isRender1, 0);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        #1;
        chk("midrst_after_busy", busy, 0);
        chk("midrst_after_count", active_count, 0);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (busy) n++;
            @(negedge clk);
        end
        chk("midrst_no_resume", n, 0);
        check_all();

`ifdef BULLET_POOL_COLLIDE_EN
        do_reset();
        player_x = 8'd50; player_y = 8'd50; player_w = 8'd8; player_h = 8'd8;
        do_spawn(50, 50, 4, 4, 2, 2, 1, 1'b0);
        do_tick(1, -1, -1);
        index1 = '0;
        #1;
        chk("collide_render", isRender1, 0);
        chk("collide_pos", position1, 16'h3434);
        check_all();
        player_x = '0; player_y = '0; player_w = '0; player_h = '0;
`endif

        // Random operations against the model.
        do_reset();
        for (int k = 0; k < 120; k++) begin
            int op = int'($urandom_range(0, 9));
            if (op < 8 && op >= 6) begin
                do_tick(1, -1, -1);
            end else begin
                do_spawn(int'($urandom_range(0, 170)), int'($urandom_range(0, 130)),
                         int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
                         int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                         int'($urandom_range(0, 7)), op >= 8);
            end
            check_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
